prbs31_generator: RTL and testbench

- Upstream PRBS31 source for the Tx_sim path. Produces one serial bit per accepted handshake from a 31-bit Fibonacci LFSR with taps 31/28 (x^31+x^28+1).
- Feeds the channel/UART Tx stage and ultimately prbs31_checker. With the same SEED, its error-free output matches the checker bit-for-bit from reset.
- Supports continuous or fixed-length burst operation, downstream backpressure, and single-shot or periodic error injection for BER testing.

---
 rtl/prbs31_generator.sv | 128 ++++++++++++
 tb/tb_prbs31_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_generator.sv
// PRBS31 (x^31+x^28+1) serial source with valid/ready handshake, burst control
// and single-shot / periodic error injection for BER testing.
module prbs31_generator #(
  parameter logic [30:0] SEED  = 31'b1101000101011010010010100011111,
  parameter int          CNT_W = 32,
  parameter int          PER_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             burst_mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             inject_err,
  input  logic [PER_W-1:0] err_period,
  output logic             data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_bits_sent,
  output logic [CNT_W-1:0] total_errors_injected
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [30:0]      sr;
  logic             flip_tag;
  logic             pend;
  logic             stop_req;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] burst_cnt;
  logic [PER_W-1:0] per_cnt;

  logic             nb, xfer, stop_now, remain, start_ok, load;
  logic             pend_eff, per_hit, flip;
  logic [PER_W-1:0] per_last;

  assign nb       = sr[30] ^ sr[27];
  assign xfer     = data_out_valid && data_out_ready;
  assign stop_now = (state == RUN) && !mode_q && (stop || stop_req);
  assign remain   = !mode_q || (burst_cnt != len_q);
  // The first bit is loaded on the start edge itself so valid rises one cycle later.
  assign start_ok = (state == IDLE) && start && !(burst_mode && (burst_len == '0));
  assign load     = start_ok ||
                    ((state == RUN) && (!data_out_valid || data_out_ready) && remain && !stop_now);

  assign per_last = err_period - PER_W'(1);
  assign per_hit  = (err_period != '0) && (per_cnt == per_last);
  assign pend_eff = pend | inject_err;
  assign flip     = pend_eff | per_hit;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                 <= IDLE;
      sr                    <= SEED;
      data_out              <= 1'b0;
      data_out_valid        <= 1'b0;
      flip_tag              <= 1'b0;
      done                  <= 1'b0;
      pend                  <= 1'b0;
      stop_req              <= 1'b0;
      mode_q                <= 1'b0;
      len_q                 <= '0;
      burst_cnt             <= '0;
      per_cnt               <= '0;
      total_bits_sent       <= '0;
      total_errors_injected <= '0;
    end else begin
      done <= 1'b0;

      if (xfer) begin
        total_bits_sent <= total_bits_sent + CNT_W'(1);
        if (flip_tag) total_errors_injected <= total_errors_injected + CNT_W'(1);
      end

      if (load) begin
        sr             <= {sr[29:0], nb};
        data_out       <= nb ^ flip;
        data_out_valid <= 1'b1;
        flip_tag       <= flip;
        per_cnt        <= (per_hit || (err_period == '0)) ? '0 : per_cnt + PER_W'(1);
      end else if (xfer) begin
        data_out_valid <= 1'b0;
      end

      // A pulse landing while the flag is set merges into it.
      pend <= load ? 1'b0 : pend_eff;

      case (state)
        IDLE: if (start) begin
          mode_q   <= burst_mode;
          len_q    <= burst_len;
          stop_req <= 1'b0;
          if (start_ok) begin
            burst_cnt <= CNT_W'(1);
            state     <= RUN;
          end else begin
            burst_cnt <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        RUN: begin
          if (load)     burst_cnt <= burst_cnt + CNT_W'(1);
          if (stop_now) stop_req  <= 1'b1;
          // Leave RUN only once nothing is left in flight.
          if (!load && (xfer || !data_out_valid)) begin
            if (stop_now) begin
              stop_req <= 1'b0;
              state    <= IDLE;
            end else if (!remain) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs31_generator.sv
// Directed bench for prbs31_generator: table-driven bursts plus hand sequences
// for start latency, stop under backpressure, zero-length bursts and mid-burst reset.
module tb_prbs31_generator;
  localparam logic [30:0] SEED = 31'b1101000101011010010010100011111;

  logic        clk = 1'b0;
  logic        rstn, start, stop, burst_mode, inject_err, data_out_ready;
  logic [31:0] burst_len;
  logic [15:0] err_period;
  logic        data_out, data_out_valid, busy, done;
  logic [31:0] total_bits_sent, total_errors_injected;

  prbs31_generator #(.SEED(SEED), .CNT_W(32), .PER_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .burst_mode(burst_mode), .burst_len(burst_len),
    .inject_err(inject_err), .err_period(err_period),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .busy(busy), .done(done),
    .total_bits_sent(total_bits_sent), .total_errors_injected(total_errors_injected)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference checker: independent LFSR advanced on every transfer.
  logic [30:0] ref_sr;
  int mon_bits, mon_errs, done_cnt, stall_fail;
  logic stall, stall_bit, exp_bit;

  always @(negedge clk) begin
    if (!rstn) begin
      ref_sr = SEED; mon_bits = 0; mon_errs = 0; done_cnt = 0;
      stall = 1'b0; stall_bit = 1'b0; stall_fail = 0;
    end else begin
      if (done) done_cnt++;
      if (stall && (!data_out_valid || data_out != stall_bit)) stall_fail++;
      stall     = data_out_valid && !data_out_ready;
      stall_bit = data_out;
      if (data_out_valid && data_out_ready) begin
        exp_bit = ref_sr[30] ^ ref_sr[27];
        ref_sr  = {ref_sr[29:0], exp_bit};
        mon_bits++;
        if (data_out != exp_bit) mon_errs++;
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0; burst_mode = 1'b0; burst_len = '0;
    inject_err = 1'b0; err_period = '0; data_out_ready = 1'b1;
    tick(); tick();
    rstn = 1'b1;
  endtask

  typedef struct {
    bit mode; int len; int period; int inj_c; bit rnd; int exp_bits; int exp_errs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 1000, 100,  99, 1'b0, 1000, 10};
    vecs[1] = '{1'b1,  500,   0,  -1, 1'b1,  500,  0};
    vecs[2] = '{1'b1,   37,   7,  -1, 1'b1,   37,  5};
    vecs[3] = '{1'b1,   20,   0,   4, 1'b0,   20,  1};
    vecs[4] = '{1'b1,    1,   1,  -1, 1'b0,    1,  1};

    // Reset state
    rstn = 1'b0; start = 1'b0; stop = 1'b0; burst_mode = 1'b0; burst_len = '0;
    inject_err = 1'b0; err_period = '0; data_out_ready = 1'b0;
    tick();
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bits", total_bits_sent, 0);
    check("rst_errs", total_errors_injected, 0);

    // Start latency and first bits 0,1,0, then stop with ready high
    do_reset();
    start = 1'b1; burst_mode = 1'b0; data_out_ready = 1'b1;
    tick(); start = 1'b0;
    check("first_valid", data_out_valid, 1);
    check("first_bit0", data_out, 0);
    check("first_busy", busy, 1);
    check("first_cnt0", total_bits_sent, 0);
    tick();
    check("first_bit1", data_out, 1);
    check("first_cnt1", total_bits_sent, 1);
    tick();
    check("first_bit2", data_out, 0);
    check("first_cnt2", total_bits_sent, 2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_valid", data_out_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_cnt", total_bits_sent, 3);

    // Table-driven bursts
    foreach (vecs[v]) begin
      int c;
      do_reset();
      burst_mode = vecs[v].mode; burst_len = vecs[v].len; err_period = 16'(vecs[v].period);
      start = 1'b1;
      c = 0;
      forever begin
        inject_err     = (c == vecs[v].inj_c);
        data_out_ready = vecs[v].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start = 1'b0;
        c++;
        if (!busy) break;
        if (c > 5000) begin
          check($sformatf("vec%0d_timeout", v), c, 0);
          break;
        end
      end
      inject_err = 1'b0;
      tick();
      check($sformatf("vec%0d_bits", v), total_bits_sent, vecs[v].exp_bits);
      check($sformatf("vec%0d_errs", v), total_errors_injected, vecs[v].exp_errs);
      check($sformatf("vec%0d_ref_bits", v), mon_bits, vecs[v].exp_bits);
      check($sformatf("vec%0d_ref_errs", v), mon_errs, vecs[v].exp_errs);
      check($sformatf("vec%0d_done", v), done_cnt, 1);
      check($sformatf("vec%0d_valid", v), data_out_valid, 0);
      check($sformatf("vec%0d_stall", v), stall_fail, 0);
    end

    // Stop while stalled, then resume the sequence
    do_reset();
    start = 1'b1; burst_mode = 1'b0; data_out_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    data_out_ready = 1'b0; stop = 1'b1;
    tick(); stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", data_out_valid, 1);
      check("hold_busy", busy, 1);
      if (i < 2) tick();
    end
    data_out_ready = 1'b1;
    tick();
    check("hold_end_valid", data_out_valid, 0);
    check("hold_end_busy", busy, 0);
    check("hold_bits", total_bits_sent, 5);
    check("hold_stall", stall_fail, 0);
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (19) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("resume_busy", busy, 0);
    check("resume_bits", total_bits_sent, 25);
    check("resume_ref_errs", mon_errs, 0);
    check("resume_done", done_cnt, 0);

    // Zero-length burst
    do_reset();
    start = 1'b1; burst_mode = 1'b1; burst_len = 0;
    tick(); start = 1'b0;
    check("zero_done", done, 1);
    check("zero_valid", data_out_valid, 0);
    tick();
    check("zero_done_end", done, 0);
    check("zero_busy", busy, 0);
    check("zero_valid2", data_out_valid, 0);

    // Reset mid-burst restarts the sequence
    do_reset();
    start = 1'b1; burst_mode = 1'b1; burst_len = 100; err_period = 3;
    tick(); start = 1'b0;
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bits", total_bits_sent, 0);
    check("mid_rst_errs", total_errors_injected, 0);
    rstn = 1'b1; err_period = 0; burst_mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("restart_bit0", data_out, 0);
    tick();
    check("restart_bit1", data_out, 1);
    tick();
    check("restart_bit2", data_out, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("restart_ref_errs", mon_errs, 0);
    check("restart_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
